// File: rtl/hamming_secded_decoder_pkg.sv
// Package: hamming_pkg
// Shared constants, enums and helpers for the SECDED Hamming(39,32) path.
//   CW_W / P_W / D_W : codeword, syndrome and data widths
//   status_e         : decode outcome as presented on the status output
//   state_e          : decoder FSM states, also exported for debug
//   is_pow2          : true for the parity-bit positions (1,2,4,...)
//   extract_data     : gathers the 32 data bits from positions 3..38
package hamming_pkg;

  localparam int CW_W = 39;
  localparam int P_W  = 6;
  localparam int D_W  = 32;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_CORR = 2'b01,
    ST_DED  = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bits fill the non-parity positions in ascending order; data[0] is at position 3.
  function automatic logic [D_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [D_W-1:0] d;
    int unsigned    k;
    d = '0;
    k = 0;
    for (int unsigned pos = 1; pos < CW_W; pos++) begin
      if (!is_pow2(pos)) begin
        d[k] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// Interface: hamming_secded_decoder_if
// CPU-side bus of the SECDED decoder.
//   master : CPU / bench side (drives wr, code_in, cnt_clr)
//   slave  : decoder side (drives results, status and debug state)
// Handshake: wr is a one-cycle write strobe, taken on a rising clk edge only when
// busy is low. A wr seen while busy is dropped and raises the sticky ovr flag.
// valid is a level that rises once the result registers are loaded and stays high
// until the next accepted wr clears it.
interface hamming_secded_decoder_if
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic              wr;
  logic [CW_W-1:0]   code_in;
  logic              cnt_clr;
  logic [D_W-1:0]    data_out;
  status_e           status;
  logic [P_W-1:0]    err_pos;
  logic              valid;
  logic              busy;
  logic              ovr;
  logic [CNT_W-1:0]  ce_cnt;
  logic [CNT_W-1:0]  de_cnt;
  state_e            dbg_state;

  modport master (
    output wr, code_in, cnt_clr,
    input  data_out, status, err_pos, valid, busy, ovr, ce_cnt, de_cnt, dbg_state
  );

  modport slave (
    input  wr, code_in, cnt_clr,
    output data_out, status, err_pos, valid, busy, ovr, ce_cnt, de_cnt, dbg_state
  );

endinterface

// File: rtl/hamming_secded_decoder_syndrome.sv
// Module: hamming_syndrome
// Combinational syndrome/overall-parity generator for a 39-bit codeword.
//   code : codeword, bit i = Hamming position i, bit 0 = overall parity
//   s    : s[k] = XOR of code bits whose position has bit k set
//   p    : XOR of all 39 bits
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0] code,
  output logic [P_W-1:0]  s,
  output logic            p
);

  always_comb begin
    s = '0;
    p = ^code;
    for (int pos = 1; pos < CW_W; pos++) begin
      for (int k = 0; k < P_W; k++) begin
        if (pos[k]) s[k] = s[k] ^ code[pos];
      end
    end
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Module: hamming_secded_decoder
// SECDED Hamming(39,32) decoder on the CPU read-back path. A codeword written on
// wr is decoded over three edges (accept, syndrome, decide) and the corrected word,
// status and error position are held with valid until the next accepted wr.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : hamming_secded_decoder_if.slave (wr, code_in, cnt_clr in;
//         data_out, status, err_pos, valid, busy, ovr, ce_cnt, de_cnt, dbg_state out)
// Build option: define HAM_ERR_COUNT_EN to build the saturating corrected/double
// error counters; otherwise ce_cnt/de_cnt read 0 and cnt_clr has no effect.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  hamming_secded_decoder_if.slave   bus
);

  if (DATA_W != D_W) begin : g_bad_data_w
    $error("hamming_secded_decoder: DATA_W must be 32");
  end

  state_e          state, state_nxt;
  logic [CW_W-1:0] code_q;
  logic [P_W-1:0]  syn_q, syn_c;
  logic            par_q, par_c;
  logic [D_W-1:0]  data_q;
  status_e         status_q;
  logic [P_W-1:0]  pos_q;
  logic            valid_q, ovr_q;
  logic            busy, accept;

  status_e         dec_status;
  logic [P_W-1:0]  dec_pos;
  logic [CW_W-1:0] fix_code;

  hamming_syndrome u_syndrome (
    .code (code_q),
    .s    (syn_c),
    .p    (par_c)
  );

  assign busy   = (state == SYND) || (state == CORR);
  assign accept = bus.wr && !busy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.wr) state_nxt = SYND;
      SYND:       state_nxt = CORR;
      CORR:       state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Odd overall parity means a single flip; the syndrome then names the position,
  // unless it points past the last position, which only multi-bit errors produce.
  always_comb begin
    dec_status = ST_OK;
    dec_pos    = '0;
    fix_code   = code_q;
    if (par_q) begin
      if (syn_q <= P_W'(CW_W - 1)) begin
        dec_status = ST_CORR;
        dec_pos    = syn_q;
        fix_code   = code_q ^ (CW_W'(1) << syn_q);
      end else begin
        dec_status = ST_DED;
      end
    end else if (syn_q != '0) begin
      dec_status = ST_DED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q   <= '0;
      syn_q    <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      status_q <= ST_OK;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (accept) begin
        code_q  <= bus.code_in;
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else if (bus.wr) begin
        ovr_q   <= 1'b1;
      end
      if (state == SYND) begin
        syn_q <= syn_c;
        par_q <= par_c;
      end
      if (state == CORR) begin
        data_q   <= extract_data(fix_code);
        status_q <= dec_status;
        pos_q    <= dec_pos;
        valid_q  <= 1'b1;
      end
    end
  end

`ifdef HAM_ERR_COUNT_EN
  logic [CNT_W-1:0] ce_q, de_q;

  // Clear takes priority over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      ce_q <= '0;
      de_q <= '0;
    end else if (state == CORR) begin
      if (dec_status == ST_CORR && ce_q != '1) ce_q <= ce_q + 1'b1;
      if (dec_status == ST_DED  && de_q != '1) de_q <= de_q + 1'b1;
    end
  end

  assign bus.ce_cnt = ce_q;
  assign bus.de_cnt = de_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.ce_cnt     = '0;
  assign bus.de_cnt     = '0;
`endif

  assign bus.data_out  = data_q;
  assign bus.status    = status_q;
  assign bus.err_pos   = pos_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy;
  assign bus.ovr       = ovr_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Testbench for hamming_secded_decoder: directed and random codewords, expected
// results queued at drive time and compared when valid rises.
module tb_hamming_secded_decoder;
  import hamming_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_ce = 0;
  int   exp_de = 0;
  logic [39:0] exp_q[$];

  hamming_secded_decoder_if #(.CNT_W(16)) bus ();

  hamming_secded_decoder #(.DATA_W(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference encoder: data in non-power-of-two positions, then parity bits, then overall parity
  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] cw;
    logic        x;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      x = 1'b0;
      for (int pos = 1; pos < 39; pos++) if (pos[b]) x ^= cw[pos];
      cw[1 << b] = x;
    end
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  function automatic logic [31:0] raw_data(input logic [38:0] cw);
    logic [31:0] d;
    int          k;
    d = '0;
    k = 0;
    for (int pos = 3; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

  // driver tasks
  task automatic push_exp(input logic [31:0] d, input status_e s, input logic [5:0] p);
    exp_q.push_back({d, s, p});
    if (s == ST_CORR) exp_ce++;
    else if (s == ST_DED) exp_de++;
  endtask

  task automatic drive_wr(input logic [38:0] c);
    @(negedge clk);
    bus.wr      = 1'b1;
    bus.code_in = c;
    @(negedge clk);
    bus.wr      = 1'b0;
  endtask

  task automatic check_counters(input string tag);
`ifdef HAM_ERR_COUNT_EN
    check({tag, "_ce_cnt"}, bus.ce_cnt, exp_ce);
    check({tag, "_de_cnt"}, bus.de_cnt, exp_de);
`else
    check({tag, "_ce_cnt"}, bus.ce_cnt, 0);
    check({tag, "_de_cnt"}, bus.de_cnt, 0);
`endif
  endtask

  // scoreboard: wait (bounded) for valid, then compare against the queue head
  task automatic wait_result(input string tag, input int exp_lat);
    logic [39:0] e;
    int          n;
    n = 0;
    check({tag, "_valid_low"}, bus.valid, 1'b0);
    while (!bus.valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"},    bus.data_out, e[39:8]);
      check({tag, "_status"},  bus.status,   e[7:6]);
      check({tag, "_err_pos"}, bus.err_pos,  e[5:0]);
      check({tag, "_busy"},    bus.busy,     1'b0);
      check_counters(tag);
    end
  endtask

  task automatic send(input string tag, input logic [38:0] c, input logic [31:0] d,
                      input status_e s, input logic [5:0] p);
    push_exp(d, s, p);
    drive_wr(c);
    wait_result(tag, 2);
  endtask

  logic [38:0] one;
  logic [38:0] cw;
  logic [31:0] rd;
  int          mode, r1, r2;

  initial begin
    one         = 39'd1;
    rst         = 1'b1;
    bus.wr      = 1'b0;
    bus.code_in = '0;
    bus.cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_valid",    bus.valid,     1'b0);
    check("rst_busy",     bus.busy,      1'b0);
    check("rst_ovr",      bus.ovr,       1'b0);
    check("rst_data",     bus.data_out,  32'h0);
    check("rst_status",   bus.status,    ST_OK);
    check("rst_err_pos",  bus.err_pos,   6'd0);
    check("rst_state",    bus.dbg_state, IDLE);
    check_counters("rst");

    // directed vectors
    send("clean",     39'h0F, 32'h1, ST_OK,   6'd0);
    send("flip5",     39'h2F, 32'h1, ST_CORR, 6'd5);
    send("flip0",     39'h0E, 32'h1, ST_CORR, 6'd0);
    send("double",    39'h09, 32'h1, ST_DED,  6'd0);
    send("flip38",    one << 38, 32'h0, ST_CORR, 6'd38);
    send("syn_gt_38", 39'h1_0000_0081, 32'h8, ST_DED, 6'd0);

    // write while busy: dropped, ovr set, first decode completes
    push_exp(32'h1, ST_OK, 6'd0);
    @(negedge clk);
    bus.wr      = 1'b1;
    bus.code_in = 39'h0F;
    @(negedge clk);
    check("ovr_busy", bus.busy, 1'b1);
    bus.code_in = 39'h2F;
    @(negedge clk);
    bus.wr = 1'b0;
    check("ovr_set", bus.ovr, 1'b1);
    wait_result("ovr_first", 1);
    check("ovr_sticky", bus.ovr, 1'b1);
    push_exp(32'h1, ST_CORR, 6'd5);
    drive_wr(39'h2F);
    check("ovr_cleared", bus.ovr, 1'b0);
    wait_result("ovr_next", 2);

    // random encoded words with 0, 1 or 2 flips
    for (int i = 0; i < 10; i++) begin
      rd   = $urandom;
      cw   = encode(rd);
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        send("rand_ok", cw, rd, ST_OK, 6'd0);
      end else if (mode == 1) begin
        r1 = $urandom_range(0, 38);
        cw = cw ^ (one << r1);
        send("rand_corr", cw, rd, ST_CORR, 6'(r1));
      end else begin
        r1 = $urandom_range(0, 38);
        r2 = (r1 + $urandom_range(1, 38)) % 39;
        cw = cw ^ (one << r1) ^ (one << r2);
        send("rand_ded", cw, raw_data(cw), ST_DED, 6'd0);
      end
    end

    // counter clear
    @(negedge clk);
    bus.cnt_clr = 1'b1;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    exp_ce = 0;
    exp_de = 0;
    check_counters("clr");
    send("cnt_a", 39'h2F, 32'h1, ST_CORR, 6'd5);
    send("cnt_b", 39'h2F, 32'h1, ST_CORR, 6'd5);
    send("cnt_c", 39'h2F, 32'h1, ST_CORR, 6'd5);
    send("cnt_d", 39'h09, 32'h1, ST_DED,  6'd0);

    // reset in the middle of a decode
    drive_wr(39'h2F);
    check("mid_state", bus.dbg_state, SYND);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ce = 0;
    exp_de = 0;
    check("mid_rst_valid", bus.valid,     1'b0);
    check("mid_rst_busy",  bus.busy,      1'b0);
    check("mid_rst_state", bus.dbg_state, IDLE);
    check("mid_rst_data",  bus.data_out,  32'h0);
    check_counters("mid_rst");
    send("post_rst", 39'h0E, 32'h1, ST_CORR, 6'd0);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
